// File: rtl/rca_word_sequencer.sv
// Wide add/subtract built from one narrow ripple-carry slice that is reused
// once per slice, least-significant first, with the carry chained through a register.

module ripple_carry_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Bit-serial carry chain through the slice
    always_comb begin
        logic carry_v;
        carry_v = cin;
        sum     = '0;
        for (int i = 0; i < W; i++) begin
            sum[i]  = a[i] ^ b[i] ^ carry_v;
            carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
        end
        cout = carry_v;
    end

endmodule

module rca_word_sequencer #(
    parameter int TOTAL_W = 32,
    parameter int SLICE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] a,
    input  logic [TOTAL_W-1:0] b,
    input  logic               cin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] sum,
    output logic               cout,
    output logic               ovf
);

    localparam int NSLICE = TOTAL_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [TOTAL_W-1:0]   a_sh_r;
    logic [TOTAL_W-1:0]   b_sh_r;
    logic [TOTAL_W-1:0]   res_sh_r;
    logic [TOTAL_W-1:0]   sum_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 carry_r;
    logic                 a_msb_r;
    logic                 b_msb_r;
    logic                 cout_r;
    logic                 ovf_r;
    logic                 out_valid_r;

    logic [SLICE_W-1:0]         slice_sum_s;
    logic                       slice_cout_s;
    logic [TOTAL_W+SLICE_W-1:0] res_cat_s;
    logic [TOTAL_W-1:0]         res_next_s;
    logic [TOTAL_W-1:0]         b_eff_s;
    logic                       last_slice_s;

    ripple_carry_adder #(.W(SLICE_W)) u_slice (
        .a    (a_sh_r[SLICE_W-1:0]),
        .b    (b_sh_r[SLICE_W-1:0]),
        .cin  (carry_r),
        .sum  (slice_sum_s),
        .cout (slice_cout_s)
    );

    // New slice enters at the top; after NSLICE shifts the word is aligned
    assign res_cat_s    = {slice_sum_s, res_sh_r};
    assign res_next_s   = res_cat_s[TOTAL_W+SLICE_W-1:SLICE_W];
    assign b_eff_s      = sub ? ~b : b;
    assign last_slice_s = (cnt_r == CNT_W'(NSLICE - 1));

    assign in_ready  = rst_n && (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // Sequencer: accept, run one slice per cycle, hold result until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            res_sh_r    <= '0;
            sum_r       <= '0;
            cnt_r       <= '0;
            carry_r     <= 1'b0;
            a_msb_r     <= 1'b0;
            b_msb_r     <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b_eff_s;
                        carry_r <= sub ? 1'b1 : cin;
                        a_msb_r <= a[TOTAL_W-1];
                        b_msb_r <= b_eff_s[TOTAL_W-1];
                        cnt_r   <= '0;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    res_sh_r <= res_next_s;
                    a_sh_r   <= a_sh_r >> SLICE_W;
                    b_sh_r   <= b_sh_r >> SLICE_W;
                    carry_r  <= slice_cout_s;
                    if (last_slice_s) begin
                        sum_r       <= res_next_s;
                        cout_r      <= slice_cout_s;
                        ovf_r       <= (a_msb_r == b_msb_r) &&
                                       (res_next_s[TOTAL_W-1] != a_msb_r);
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Scoreboard bench: expected results come from plain integer arithmetic and
// are queued at accept; a negedge monitor compares on each output handshake.

module tb_rca_word_sequencer;

    localparam int TW = 32;
    localparam int NS = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] sum;
    logic          cout;
    logic          ovf;

    typedef struct {
        logic [TW-1:0] sum;
        logic          cout;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    rca_word_sequencer #(.TOTAL_W(TW), .SLICE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: signed/unsigned integer arithmetic on 64-bit values
    function automatic exp_t model(input logic [TW-1:0] oa, input logic [TW-1:0] ob,
                                   input logic ocin, input logic osub);
        exp_t        e;
        longint      sa = longint'(signed'(oa));
        longint      sbv = longint'(signed'(ob));
        longint      r;
        logic [63:0] u;
        if (osub) begin
            r      = sa - sbv;
            e.cout = (oa >= ob);
        end else begin
            r      = sa + sbv + longint'(ocin);
            u      = 64'(oa) + 64'(ob) + 64'(ocin);
            e.cout = u[32];
        end
        e.sum = r[TW-1:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return e;
    endfunction

    // Monitor: one comparison per output handshake
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
                check("ovf", 64'(ovf), 64'(e.ovf));
            end
        end
    end

    // Called at a negedge where in_ready is high: queue model, release request
    task automatic push_and_release();
        sb.push_back(model(a, b, cin, sub));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_accept();
        bit got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        else push_and_release();
    endtask

    // Count edges from accept until out_valid, then step past the next edge
    task automatic wait_result(input bit chk_lat);
        int n = 0;
        bit got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("result_timeout", 64'd0, 64'd1);
        else if (chk_lat) check("latency", 64'(n), 64'(NS));
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [TW-1:0] ta, input logic [TW-1:0] tb,
                          input logic tcin, input logic tsub);
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        wait_accept();
        wait_result(1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(32'h12345678, 32'h11111111, 1'b1, 1'b0);
        run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1);
        run_op(32'h00000007, 32'h00000005, 1'b1, 1'b1);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1);

        // Backpressure with a new request waiting
        out_ready = 1'b0;
        a = 32'hDEADBEEF; b = 32'h01234567; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        e0 = model(a, b, cin, sub);
        wait_accept();
        wait_result(1'b1);
        a = 32'h0000F00D; b = 32'h00000ACE; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_sum", 64'(sum), 64'(e0.sum));
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hs_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        push_and_release();
        wait_result(1'b1);

        for (int i = 0; i < 25; i++) begin
            run_op($urandom, $urandom, 1'($urandom), 1'($urandom));
        end

        // Reset after slice 3 of an in-flight add
        a = 32'h0F0F0F0F; b = 32'h10101010; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        wait_accept();
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        run_op(32'h00000003, 32'h00000004, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
